clk_reset_sequencer: RTL and testbench
======================================

// Module: clk_reset_sequencer
// PURPOSE
//   Consumer end of the clock generator: runs on the generated clock and turns the async
//   MMCM/PLL LOCKED status into a clean, debounced, stretched core reset.
//   Sits between femtoPLL and the processor/SoC core; releases resetn_out only after a stable lock.
//   Re-asserts reset on loss of lock and flags the event.
// PARAMETERS
//   SYNC_STAGES  2     synchroniser depth for pll_locked (>=2)
//   LOCK_STABLE  1024  cycles pll_locked (synced) must stay high before reset hold starts (>=1)
//   RESET_HOLD   16    cycles resetn_out stays low after lock is deemed stable (>=1)
// PORTS
//   clk           in   1  generated system clock (single clock domain)
//   reset         in   1  asynchronous, active-high reset
//   pll_locked    in   1  LOCKED from MMCM, asynchronous to clk
//   lock_lost_clr in   1  clears the lock_lost sticky flag (1-cycle pulse)
//   resetn_out    out  1  active-low core reset, registered
//   ready         out  1  high while in RUN (equal to resetn_out)
//   lock_lost     out  1  sticky: lock dropped while in RUN
//   loss_count    out  8  number of RUN->lock-loss events (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, active-high): all flops 0; state=WAIT_LOCK, cnt=0.
//     resetn_out=0, ready=0, lock_lost=0, loss_count=0.
//   locked_s = pll_locked through SYNC_STAGES flops; the FSM uses only locked_s.
//   States:
//     WAIT_LOCK: cnt=0; locked_s=1 -> STABLE.
//     STABLE: cnt++ while locked_s; locked_s=0 -> WAIT_LOCK.
//       cnt==LOCK_STABLE-1 -> HOLD, cnt=0.
//     HOLD: cnt++; locked_s=0 -> WAIT_LOCK.
//       cnt==RESET_HOLD-1 -> RUN.
//     RUN: locked_s=0 -> WAIT_LOCK; lock_lost<=1; loss_count++.
//   resetn_out/ready registered from next_state==RUN; they change on the same edge as the state.
//   Latency: pll_locked high (held) -> resetn_out rises after SYNC_STAGES+1+LOCK_STABLE+RESET_HOLD edges.
//   Lock drop in RUN: resetn_out falls SYNC_STAGES+1 edges after pll_locked falls.
//     Full sequence restarts on re-lock.
//   Glitch on pll_locked shorter than LOCK_STABLE in STABLE/HOLD: counter restarts, resetn_out stays 0.
//   cnt width = $clog2(max(LOCK_STABLE,RESET_HOLD)+1). No wrap: cnt never exceeds terminal value.
//   lock_lost_clr: clears lock_lost next edge. Same-cycle clear and new loss -> lock_lost=1 (loss wins).
//   Reset mid-sequence (any state): immediate return to reset values. Synchroniser also cleared.
// CONFIGURATION
//   CLK_SEQ_LOSS_COUNT_EN defined:
//     loss_count is an 8-bit counter of RUN->WAIT_LOCK transitions.
//     Saturates at 255. Not cleared by lock_lost_clr, only by reset.
//   Undefined: no counter flops; loss_count tied to 8'd0. Port always present.
// STRUCTURE
//   Package clk_seq_pkg:
//     state_t enum {WAIT_LOCK, STABLE, HOLD, RUN} (2-bit encoding 0..3).
//     LOSS_CNT_W=8 and LOSS_CNT_MAX=8'hFF constants.
//   Sub-module sync_ff #(STAGES):
//     generic N-flop async-reset synchroniser.
//     Instanced once for pll_locked and reusable elsewhere.
//   FSM, counter and flags live in clk_reset_sequencer.
// TESTING (bench: SYNC_STAGES=2, LOCK_STABLE=8, RESET_HOLD=4, 10 ns clk)
//   1. Power-up with pll_locked held high:
//      resetn_out=0 until exactly edge 15 after reset release.
//      Then ready=1, lock_lost=0.
//   2. pll_locked high 5 cycles, low 1 cycle, then high:
//      counter restarts; resetn_out rises 15 edges after the final rise.
//   3. In RUN, drop pll_locked:
//      resetn_out=0 and lock_lost=1 at edge 3 after the fall.
//      loss_count=1 (macro on) or 0 (macro off).
//      Re-lock -> resetn_out=1 after 15 more edges.
//   4. lock_lost_clr pulse in the same cycle as a new RUN lock loss:
//      lock_lost stays 1. A later isolated pulse clears it to 0.
//   5. Assert reset during HOLD (cnt=2):
//      all outputs 0 immediately (async).
//      After release with pll_locked high, the full 15-edge sequence repeats.
//   6. Macro on, 260 loss events: loss_count saturates at 255, no wrap to 0.

Source files
------------

// File: rtl/clk_seq_pkg.sv
// Shared types and constants for the clock/reset sequencer.
//   state_t      : sequencer states, 2-bit encoding 0..3
//   LOSS_CNT_W   : width of the lock-loss event counter
//   LOSS_CNT_MAX : saturation value of the lock-loss event counter
//   max_u        : helper used to size the shared stable/hold counter
package clk_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned           LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_reset_sequencer_sync_ff.sv
// Generic N-flop synchroniser with asynchronous active-high clear.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
// STAGES must be >= 2.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d = STAGES'({sync_q, d});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_reset_sequencer.sv
// Turns an asynchronous PLL/MMCM LOCKED into a debounced, stretched core reset.
//   clk           : generated system clock
//   reset         : asynchronous active-high reset
//   pll_locked    : LOCKED from the clock generator, asynchronous to clk
//   lock_lost_clr : one-cycle pulse clearing the lock_lost flag
//   resetn_out    : active-low core reset (registered)
//   ready         : high while running (same flop as resetn_out)
//   lock_lost     : sticky, set when lock drops while running
//   loss_count    : saturating count of run->lock-loss events
// Optional feature: define CLK_SEQ_LOSS_COUNT_EN to build the loss counter;
// otherwise loss_count is tied to zero.
module clk_reset_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned RESET_HOLD  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  lock_lost_clr,
  output logic                  resetn_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int unsigned     CNT_W       = $clog2(max_u(LOCK_STABLE, RESET_HOLD) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);

  logic             locked_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resetn_q, resetn_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lost_event;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // State and counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; any drop of locked_s before RUN restarts the whole sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow next_state so they switch on the same edge as the state.
  always_comb begin
    lost_event  = (state_q == RUN) && (state_d != RUN);
    resetn_d    = (state_d == RUN);
    lock_lost_d = lock_lost_q;
    if (lock_lost_clr) lock_lost_d = 1'b0;
    if (lost_event)    lock_lost_d = 1'b1;   // a new loss beats a same-cycle clear
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resetn_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      resetn_q    <= resetn_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign resetn_out = resetn_q;
  assign ready      = resetn_q;
  assign lock_lost  = lock_lost_q;

`ifdef CLK_SEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  // Saturating event counter; only reset clears it.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lost_event && (loss_cnt_q != LOSS_CNT_MAX)) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_count = loss_cnt_q;
`else
  assign loss_count = LOSS_CNT_W'(0);
`endif

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer (SYNC_STAGES=2, LOCK_STABLE=8, RESET_HOLD=4).
// Reference model: resetn is high once the synchronised lock has been seen
// high on LOCK_STABLE+RESET_HOLD+1 consecutive edges; the synchronised lock is
// the raw input delayed by SYNC_STAGES edges.
module tb_clk_reset_sequencer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned LS   = 8;
  localparam int unsigned RH   = 4;
  localparam int          SEQ  = LS + RH + 1;          // locked_s edges needed
  localparam int          LAT  = SYNC + 1 + LS + RH;   // pll_locked rise -> resetn rise

`ifdef CLK_SEQ_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic       resetn_out, ready, lock_lost;
  logic [7:0] loss_count;

  int checks = 0;
  int failures = 0;

  clk_reset_sequencer #(
    .SYNC_STAGES (SYNC),
    .LOCK_STABLE (LS),
    .RESET_HOLD  (RH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .lock_lost_clr (lock_lost_clr),
    .resetn_out    (resetn_out),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .loss_count    (loss_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_r1, m_r2;     // consecutive-high run length of pll_locked, 1 and 2 edges back
  logic       m_resetn, m_lost;
  logic [7:0] m_cnt;
  logic       m_nr, m_loss;

  assign m_nr   = (m_r2 >= SEQ);
  assign m_loss = m_resetn && !m_nr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r1     <= 0;
      m_r2     <= 0;
      m_resetn <= 1'b0;
      m_lost   <= 1'b0;
      m_cnt    <= 8'd0;
    end else begin
      m_r2     <= m_r1;
      m_r1     <= pll_locked ? ((m_r1 < 100000) ? m_r1 + 1 : m_r1) : 0;
      m_resetn <= m_nr;
      if (m_loss)             m_lost <= 1'b1;
      else if (lock_lost_clr) m_lost <= 1'b0;
      if (CNT_EN && m_loss && (m_cnt != 8'd255)) m_cnt <= m_cnt + 8'd1;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick(input logic p, input logic clr);
    pll_locked    = p;
    lock_lost_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic p);
    @(negedge clk);
    reset = 1'b1;
    pll_locked = p;
    lock_lost_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(1'b0);
    checks++;
    if ({resetn_out, ready, lock_lost, loss_count} !== 11'd0) begin
      failures++;
      $display("FAIL reset_state: got r=%b rdy=%b ll=%b cnt=%0d, want all 0",
               resetn_out, ready, lock_lost, loss_count);
    end
  endtask

  task automatic test_powerup();
    apply_reset(1'b1);
    for (int e = 1; e <= LAT + 3; e++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (resetn_out !== logic'(e >= LAT) || ready !== logic'(e >= LAT) || lock_lost !== 1'b0) begin
        failures++;
        $display("FAIL powerup_edge%0d: got r=%b rdy=%b ll=%b, want r=%b rdy=%b ll=0",
                 e, resetn_out, ready, lock_lost, e >= LAT, e >= LAT);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int e = 1; e <= LAT + 2; e++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (resetn_out !== logic'(e >= LAT) || resetn_out !== m_resetn) begin
        failures++;
        $display("FAIL glitch_edge%0d: got r=%b, want r=%b (model %b)",
                 e, resetn_out, e >= LAT, m_resetn);
      end
    end
  endtask

  // Enters from RUN (left by test_glitch with no prior losses).
  task automatic test_lock_drop();
    logic [7:0] exp_cnt;
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    for (int e = 1; e <= 3; e++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (resetn_out !== logic'(e < 3) || lock_lost !== logic'(e >= 3)) begin
        failures++;
        $display("FAIL drop_edge%0d: got r=%b ll=%b, want r=%b ll=%b",
                 e, resetn_out, lock_lost, e < 3, e >= 3);
      end
    end
    checks++;
    if (loss_count !== exp_cnt) begin
      failures++;
      $display("FAIL drop_loss_count: got %0d, want %0d", loss_count, exp_cnt);
    end
    for (int e = 1; e <= LAT + 1; e++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (resetn_out !== logic'(e >= LAT) || lock_lost !== 1'b1) begin
        failures++;
        $display("FAIL relock_edge%0d: got r=%b ll=%b, want r=%b ll=1",
                 e, resetn_out, lock_lost, e >= LAT);
      end
    end
  endtask

  // Enters from RUN with lock_lost already set; clear it first.
  task automatic test_clr_race();
    tick(1'b1, 1'b1);
    checks++;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL clr_isolated_pre: got ll=%b, want 0", lock_lost);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);                       // loss edge coincides with clear
    checks++;
    if (lock_lost !== 1'b1 || resetn_out !== 1'b0) begin
      failures++;
      $display("FAIL clr_vs_loss: got ll=%b r=%b, want ll=1 r=0", lock_lost, resetn_out);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    checks++;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL clr_isolated: got ll=%b, want 0", lock_lost);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_in_hold();
    apply_reset(1'b1);
    for (int e = 1; e <= LAT; e++) tick(1'b1, 1'b0);
    for (int e = 1; e <= 3; e++) tick(1'b0, 1'b0);   // loss: lock_lost set
    for (int e = 1; e <= 13; e++) tick(1'b1, 1'b0);  // back to HOLD, cnt=2
    checks++;
    if (lock_lost !== 1'b1 || resetn_out !== 1'b0 || loss_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
      failures++;
      $display("FAIL hold_pre_reset: got ll=%b r=%b cnt=%0d, want ll=1 r=0 cnt=%0d",
               lock_lost, resetn_out, loss_count, CNT_EN ? 1 : 0);
    end
    #2;
    reset = 1'b1;                            // mid-cycle, no clock edge
    #1;
    checks++;
    if ({resetn_out, ready, lock_lost, loss_count} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset: got r=%b rdy=%b ll=%b cnt=%0d, want all 0",
               resetn_out, ready, lock_lost, loss_count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (resetn_out !== logic'(e >= LAT)) begin
        failures++;
        $display("FAIL post_reset_edge%0d: got r=%b, want %b", e, resetn_out, e >= LAT);
      end
    end
  endtask

  task automatic test_random();
    logic p;
    int   run_left;
    apply_reset(1'b0);
    p = 1'b0;
    run_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (run_left == 0) begin
        p = ~p;
        run_left = p ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 5));
      end
      run_left--;
      tick(p, ($urandom_range(0, 7) == 0));
      checks++;
      if ({resetn_out, ready, lock_lost, loss_count} !== {m_resetn, m_resetn, m_lost, m_cnt}) begin
        failures++;
        $display("FAIL random_cyc%0d: got r=%b rdy=%b ll=%b cnt=%0d, want r=%b rdy=%b ll=%b cnt=%0d",
                 c, resetn_out, ready, lock_lost, loss_count, m_resetn, m_resetn, m_lost, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_final;
    exp_final = CNT_EN ? 8'd255 : 8'd0;
    apply_reset(1'b0);
    for (int ev = 1; ev <= 260; ev++) begin
      for (int e = 0; e < LAT; e++) tick(1'b1, 1'b0);
      for (int e = 0; e < 3; e++) tick(1'b0, ($urandom_range(0, 3) == 0));
      checks++;
      if (loss_count !== m_cnt || lock_lost !== m_lost) begin
        failures++;
        $display("FAIL sat_event%0d: got cnt=%0d ll=%b, want cnt=%0d ll=%b",
                 ev, loss_count, lock_lost, m_cnt, m_lost);
      end
    end
    checks++;
    if (loss_count !== exp_final) begin
      failures++;
      $display("FAIL sat_final: got cnt=%0d, want %0d", loss_count, exp_final);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_glitch();
    test_lock_drop();
    test_clr_race();
    test_reset_in_hold();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
